// File: rtl/connect_four_pkg.sv
// connect_four_pkg: board geometry, FSM encoding and cell/direction helpers
package connect_four_pkg;
  localparam int ROWS  = 6;
  localparam int COLS  = 7;
  localparam int CELLS = ROWS * COLS;
  typedef enum logic [2:0] {IDLE, SCAN, PLACE, CHECK, GAME_OVER} state_t;
  function automatic logic [5:0] cell_idx(input int r, input int c);
    return 6'(r * COLS + c);
  endfunction
  function automatic logic in_bounds(input int r, input int c);
    return r >= 0 && r < ROWS && c >= 0 && c < COLS;
  endfunction
  function automatic int dir_dr(input logic [1:0] d);
    return d == 2'd0 ? 0 : 1;
  endfunction
  function automatic int dir_dc(input logic [1:0] d);
    return d == 2'd1 ? 0 : d == 2'd3 ? -1 : 1;
  endfunction
endpackage

// File: rtl/connect_four_run_count.sv
// connect_four_run_count: length of the same-owner run through the placed cell along one direction (used with WIN_DETECT_EN)
module connect_four_run_count
    import connect_four_pkg::*;
(
    input  logic [CELLS-1:0] game_data,
    input  logic [CELLS-1:0] empty,
    input  logic [2:0]       row,
    input  logic [2:0]       col,
    input  logic             owner,
    input  logic [1:0]       dir,
    output logic [2:0]       run
);

    logic fwd;
    logic bwd;
    int   dr;
    int   dc;

    function automatic logic hit(input logic [CELLS-1:0] gd, input logic [CELLS-1:0] em,
                                 input logic own, input int r, input int c);
        return in_bounds(r, c) && !em[cell_idx(r, c)] && gd[cell_idx(r, c)] == own;
    endfunction

    // Walk up to three cells each way; a run stops at the first miss or board edge
    always_comb begin
        run = 3'd1;
        fwd = 1'b1;
        bwd = 1'b1;
        dr  = dir_dr(dir);
        dc  = dir_dc(dir);
        for (int k = 1; k <= 3; k++) begin
            fwd = fwd && hit(game_data, empty, owner, int'(row) + k * dr, int'(col) + k * dc);
            bwd = bwd && hit(game_data, empty, owner, int'(row) - k * dr, int'(col) - k * dc);
            run = run + {2'b00, fwd} + {2'b00, bwd};
        end
    end

endmodule

// File: rtl/connect_four_board.sv
// connect_four_board: Connect Four game-state engine with gravity drop; WIN_DETECT_EN adds four-in-a-row detection
module connect_four_board
    import connect_four_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             new_game,
    input  logic [2:0]       col_sel,
    input  logic             drop,
    output logic [CELLS-1:0] game_data,
    output logic [CELLS-1:0] empty,
    output logic             current_player,
    output logic             busy,
    output logic             move_ok,
    output logic             move_err,
    output logic             board_full,
    output logic             winner_valid,
    output logic             winner
);

    state_t     state;
    logic [2:0] row;
    logic [2:0] col;
    logic [5:0] moves;
    logic [5:0] idx;

    assign idx  = cell_idx(int'(row), int'(col));
    assign busy = state != IDLE && state != GAME_OVER;

`ifdef WIN_DETECT_EN
    logic [1:0] dir;
    logic       owner;
    logic [2:0] run;

    connect_four_run_count u_run (
        .game_data (game_data),
        .empty     (empty),
        .row       (row),
        .col       (col),
        .owner     (owner),
        .dir       (dir),
        .run       (run)
    );
`else
    assign winner_valid = 1'b0;
    assign winner       = 1'b0;
`endif

    // Drop FSM: scan the column bottom-up, place, optionally check for a win
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            row            <= 3'd0;
            col            <= 3'd0;
            moves          <= 6'd0;
            empty          <= '1;
            game_data      <= '0;
            current_player <= 1'b0;
            move_ok        <= 1'b0;
            move_err       <= 1'b0;
            board_full     <= 1'b0;
`ifdef WIN_DETECT_EN
            dir            <= 2'd0;
            owner          <= 1'b0;
            winner_valid   <= 1'b0;
            winner         <= 1'b0;
`endif
        end else if (new_game) begin
            state          <= IDLE;
            row            <= 3'd0;
            col            <= 3'd0;
            moves          <= 6'd0;
            empty          <= '1;
            game_data      <= '0;
            current_player <= 1'b0;
            move_ok        <= 1'b0;
            move_err       <= 1'b0;
            board_full     <= 1'b0;
`ifdef WIN_DETECT_EN
            dir            <= 2'd0;
            owner          <= 1'b0;
            winner_valid   <= 1'b0;
            winner         <= 1'b0;
`endif
        end else begin
            move_ok  <= 1'b0;
            move_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (drop) begin
                        if (col_sel <= 3'd6) begin
                            col   <= col_sel;
                            row   <= 3'd0;
                            state <= SCAN;
                        end else begin
                            move_err <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (empty[idx]) begin
                        state <= PLACE;
                    end else if (row == 3'd5) begin
                        move_err <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        row <= row + 3'd1;
                    end
                end
                PLACE: begin
                    empty[idx]     <= 1'b0;
                    game_data[idx] <= current_player;
                    current_player <= ~current_player;
                    moves          <= moves + 6'd1;
                    move_ok        <= 1'b1;
                    board_full     <= moves == 6'd41;
`ifdef WIN_DETECT_EN
                    owner          <= current_player;
                    dir            <= 2'd0;
                    state          <= CHECK;
`else
                    state          <= moves == 6'd41 ? GAME_OVER : IDLE;
`endif
                end
`ifdef WIN_DETECT_EN
                CHECK: begin
                    if (run >= 3'd4) begin
                        winner_valid <= 1'b1;
                        winner       <= owner;
                        state        <= GAME_OVER;
                    end else if (dir == 2'd3) begin
                        state <= board_full ? GAME_OVER : IDLE;
                    end else begin
                        dir <= dir + 2'd1;
                    end
                end
`endif
                GAME_OVER: begin
                    if (drop) move_err <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_connect_four_board.sv
// tb_connect_four_board: directed scoreboard bench for connect_four_board (win checks only when WIN_DETECT_EN is defined)
module tb_connect_four_board;

    logic        clk = 1'b0;
    logic        reset;
    logic        new_game;
    logic [2:0]  col_sel;
    logic        drop;
    logic [41:0] game_data;
    logic [41:0] empty;
    logic        current_player;
    logic        busy;
    logic        move_ok;
    logic        move_err;
    logic        board_full;
    logic        winner_valid;
    logic        winner;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          ok;
        int          lat;
        logic [41:0] emp;
        logic [41:0] dat;
        logic        plr;
        logic        full;
    } exp_t;

    exp_t exp_q[$];

    logic [41:0] m_empty;
    logic [41:0] m_data;
    logic        m_player;
    int          m_moves;
    bit          m_over;

    connect_four_board dut (
        .clk            (clk),
        .reset          (reset),
        .new_game       (new_game),
        .col_sel        (col_sel),
        .drop           (drop),
        .game_data      (game_data),
        .empty          (empty),
        .current_player (current_player),
        .busy           (busy),
        .move_ok        (move_ok),
        .move_err       (move_err),
        .board_full     (board_full),
        .winner_valid   (winner_valid),
        .winner         (winner)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_empty  = '1;
        m_data   = '0;
        m_player = 1'b0;
        m_moves  = 0;
        m_over   = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_empty"}, empty, m_empty);
        check({tag, "_data"}, game_data, m_data);
        check({tag, "_player"}, current_player, m_player);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_ok"}, move_ok, 1'b0);
        check({tag, "_err"}, move_err, 1'b0);
        check({tag, "_full"}, board_full, 1'b0);
        check({tag, "_winv"}, winner_valid, 1'b0);
        check({tag, "_win"}, winner, 1'b0);
    endtask

    task automatic do_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(posedge clk);
        #1 new_game = 1'b0;
        model_reset();
        @(negedge clk);
        check_cleared("new_game");
    endtask

    task automatic do_drop(input int c, input bit extra);
        exp_t e;
        int   r;
        int   lat;
        int   n;
        bit   done;
        e.ok  = 1'b0;
        e.lat = 1;
        if (!m_over && c < 7) begin
            r = 0;
            while (r < 6 && !m_empty[r*7+c]) r++;
            if (r == 6) begin
                e.lat = 7;
            end else begin
                e.ok = 1'b1;
                e.lat = 3 + r;
                m_empty[r*7+c] = 1'b0;
                m_data[r*7+c] = m_player;
                m_player = ~m_player;
                m_moves++;
                if (m_moves == 42) m_over = 1'b1;
            end
        end
        e.emp  = m_empty;
        e.dat  = m_data;
        e.plr  = m_player;
        e.full = m_moves == 42;
        exp_q.push_back(e);
        @(negedge clk);
        col_sel = 3'(c);
        drop = 1'b1;
        @(posedge clk);
        #1 drop = 1'b0;
        lat  = 1;
        done = 1'b0;
        while (!done && lat <= 20) begin
            @(negedge clk);
            if (move_ok || move_err) begin
                done = 1'b1;
            end else begin
                if (extra && lat == 1) begin
                    check("busy_in_scan", busy, 1'b1);
                    col_sel = 3'd4;
                    drop = 1'b1;
                end
                @(posedge clk);
                #1 drop = 1'b0;
                lat++;
            end
        end
        check("resp_seen", done, 1'b1);
        e = exp_q.pop_front();
        check("move_ok", move_ok, e.ok);
        check("move_err", move_err, !e.ok);
        check("latency", lat, e.lat);
        check("empty", empty, e.emp);
        check("game_data", game_data & ~empty, e.dat & ~e.emp);
        check("player", current_player, e.plr);
        check("board_full", board_full, e.full);
        n = 0;
        while (busy && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("idle_after", busy, 1'b0);
    endtask

    int fill_col[8] = '{0, 2, 3, 6, 0, 1, 4, 5};
    int fill_cnt[8] = '{1, 6, 6, 6, 5, 6, 6, 6};

    initial begin
        int seen;
        reset    = 1'b1;
        new_game = 1'b0;
        drop     = 1'b0;
        col_sel  = 3'd0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_cleared("reset");
        reset = 1'b0;
        @(negedge clk);

        do_drop(3, 1'b0);

        do_new_game();
        for (int i = 0; i < 7; i++) do_drop(0, 1'b0);

        do_drop(7, 1'b0);
        do_drop(2, 1'b1);

`ifdef WIN_DETECT_EN
        do_new_game();
        do_drop(0, 1'b0);
        do_drop(0, 1'b0);
        do_drop(1, 1'b0);
        do_drop(1, 1'b0);
        do_drop(2, 1'b0);
        do_drop(2, 1'b0);
        do_drop(3, 1'b0);
        check("win_valid", winner_valid, 1'b1);
        check("win_player", winner, 1'b0);
        m_over = 1'b1;
        do_drop(5, 1'b0);
`endif

        do_new_game();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < fill_cnt[i]; j++) do_drop(fill_col[i], 1'b0);
        check("full_no_win", winner_valid, 1'b0);
        do_drop(3, 1'b0);
        do_new_game();

        for (int i = 0; i < 4; i++) do_drop(0, 1'b0);
        @(negedge clk);
        col_sel = 3'd0;
        drop = 1'b1;
        @(posedge clk);
        #1 drop = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("scan_row4_busy", busy, 1'b1);
        reset = 1'b1;
        model_reset();
        #1;
        check_cleared("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (move_ok) seen++;
        end
        check("no_late_ok", seen, 0);
        check("post_reset_empty", empty, m_empty);
        check("post_reset_data", game_data, m_data);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/connect_four_board.md
Name: connect_four_board

Overview:
- Game-state engine for Connect Four, directly upstream of connect_four_vga.
- Accepts debounced column-drop requests and applies gravity to place each piece in the lowest free row.
- Alternates players, tracks fill count and optionally detects a four-in-a-row win.
- Drives the 42-bit game_data/empty board vectors that the VGA renderer consumes.

Parameters:
- ROWS, 6, board rows (row 0 = bottom)
- COLS, 7, board columns (col 0 = left)
- CELLS, 42, ROWS*COLS; width of board vectors

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- new_game  input  1  synchronous clear pulse; returns board to reset contents
- col_sel  input  3  target column for drop, valid with drop
- drop  input  1  single-cycle request pulse, synchronous to clk
- game_data  output  42  cell owner, bit index row*COLS+col; 0 = player one, 1 = player two; meaningful only where empty=0
- empty  output  42  1 = cell unoccupied
- current_player  output  1  player whose move is next
- busy  output  1  high in every state except IDLE and GAME_OVER
- move_ok  output  1  one-cycle pulse: piece placed
- move_err  output  1  one-cycle pulse: request rejected
- board_full  output  1  all 42 cells occupied
- winner_valid  output  1  a win has been detected (sticky until reset/new_game)
- winner  output  1  winning player, valid with winner_valid

Behaviour:
- Reset values:
  - empty = all ones; game_data = 0; current_player = 0; busy = 0; move_ok = 0; move_err = 0; board_full = 0; winner_valid = 0; winner = 0.
  - FSM = IDLE; move counter = 0.
- new_game: same effect as reset, applied on the clock edge. Takes priority over every other input in every state.
- FSM states: IDLE, SCAN, PLACE, CHECK, GAME_OVER.
- IDLE:
  - drop with col_sel <= 6: latch column; row counter = 0; go to SCAN.
  - drop with col_sel >= 7: pulse move_err; stay in IDLE.
- SCAN:
  - One row per cycle; test empty[row*COLS+col].
  - Row empty: go to PLACE.
  - Row occupied and row = 5: pulse move_err (column full); go to IDLE.
  - Otherwise increment row.
- PLACE:
  - Clear empty bit; write current_player into the game_data bit.
  - Toggle current_player; increment 6-bit move counter.
  - Pulse move_ok in the following cycle, coincident with the updated vectors.
  - Then CHECK if WIN_DETECT_EN is defined, else IDLE (or GAME_OVER when counter = 42).
- Latency: drop sampled at edge k, target row r → new piece visible and move_ok high in cycle k+3+r (best case 3, worst case 8).
- drop while busy: ignored, no queuing, no error pulse.
- board_full asserts in the same cycle the 42nd piece becomes visible. FSM then enters GAME_OVER.
- GAME_OVER: any drop pulses move_err. Only reset or new_game leave this state.
- Reset asserted mid-operation: immediate return to reset values; any partial move is discarded.

Optional Feature:
- Macro WIN_DETECT_EN.
- Defined:
  - CHECK spends 4 cycles, one per direction: horizontal, vertical, diagonal /, diagonal \.
  - Each cycle counts contiguous same-owner cells from the placed cell, up to 3 each way, with bounds checks at board edges.
  - Total run >= 4: set winner_valid, winner = owner of placed piece; go to GAME_OVER.
  - Win on the 42nd piece reports both board_full and winner_valid.
  - No win after 4 cycles: IDLE, or GAME_OVER if full.
  - Latency to move_ok is unchanged.
- Undefined: CHECK state omitted; winner_valid and winner tied to 0.

Decomposition:
- Package connect_four_pkg:
  - ROWS, COLS, CELLS constants.
  - FSM state encoding.
  - Cell-index function (row*COLS+col).
  - Direction step constants (dr, dc).
- Sub-module connect_four_run_count, combinational:
  - Inputs: board vectors, placed row/col, owner, direction.
  - Output: 3-bit run length including the placed cell.
  - Instantiated only under WIN_DETECT_EN.

Test Plan:
- Reset, then drop col 3 → move_ok 3 cycles later; empty[3]=0, game_data[3]=0, current_player=1.
- Six drops col 0 fill rows 0-5 with alternating owners 0,1,0,1,0,1; seventh drop col 0 → move_err after 6 SCAN cycles, board unchanged.
- drop with col_sel=7 → move_err next cycle, no state change; drop pulsed while busy → ignored, only one piece placed.
- WIN_DETECT_EN: player 0 cols 0,1,2,3, player 1 cols 0,1,2 interleaved → winner_valid=1, winner=0 after 4th piece, FSM in GAME_OVER, next drop → move_err.
- Fill all 42 cells with a no-win pattern → board_full=1, winner_valid=0; new_game → empty all ones, current_player=0.
- Assert reset during SCAN of row 4 → all outputs at reset values immediately; the partial move never appears on the vectors.
